// File: rtl/stream_muxn_pkg.sv
// ---------------------------------------------------------------------------
// stream_muxn_pkg
// Shared types and constants for the N-way stream multiplexer and its
// arbiter.
//   stream_mux_state_t : packet-lock state of the multiplexer
//   ARB_FIXED / ARB_RR : arbitration modes (fixed priority / round-robin)
//   sel_width()        : channel-index width, never narrower than one bit
// ---------------------------------------------------------------------------
package stream_muxn_pkg;

  typedef enum logic {
    MUX_IDLE,
    MUX_LOCKED
  } stream_mux_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_muxn_if.sv
// ---------------------------------------------------------------------------
// stream_muxn_if
// Bundles the N input streams and the single output stream of stream_muxn.
//   in_valid/in_last/in_data : per-channel source words (in_data[i] = ch i)
//   in_ready                 : per-channel accept from the mux
//   out_valid/out_last/out_data/out_sel : registered output word and the
//                              channel it came from
//   out_ready                : downstream accept
// Modports:
//   slave  : the multiplexer side
//   master : the environment side (sources and sink)
// ---------------------------------------------------------------------------
interface stream_muxn_if #(
  parameter int WIDTH = 64,
  parameter int N     = 4
);

  localparam int SEL_W = stream_muxn_pkg::sel_width(N);

  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_last;
  logic [N-1:0][WIDTH-1:0] in_data;
  logic [N-1:0]            in_ready;
  logic                    out_valid;
  logic                    out_last;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data, out_sel
  );

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data, out_sel
  );

endinterface

// File: rtl/stream_arb_n.sv
// ---------------------------------------------------------------------------
// stream_arb_n
// Combinational N-way arbiter.
//   MODE = ARB_FIXED : lowest-index asserted request wins (ptr ignored)
//   MODE = ARB_RR    : search starts at ptr and wraps N-1 -> 0
// Ports:
//   req   in  N      request vector
//   ptr   in  SEL_W  round-robin start index
//   grant out SEL_W  index of the winning request (0 when none)
//   any   out 1      at least one request asserted
// ---------------------------------------------------------------------------
module stream_arb_n
  import stream_muxn_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = ARB_FIXED,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             any
);

  logic found;
  int   idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves a variable unassigned would infer a latch.
    grant = '0;
    found = 1'b0;
    idx   = 0;
    any   = |req;
    if (MODE == ARB_RR) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!found && req[idx]) begin
          found = 1'b1;
          grant = SEL_W'(idx);
        end
      end
    end else begin
      // Descending scan: the last hit, i.e. the lowest index, wins.
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) grant = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/stream_muxn.sv
// ---------------------------------------------------------------------------
// stream_muxn
// N-way stream multiplexer with packet locking and a registered output
// stage. An internal arbiter picks a channel; once a multi-word packet has
// started, the channel stays locked until its last word is accepted.
// Single-entry output register: a new word loads when the register is
// empty or being drained (load = ~out_valid | out_ready).
//
// Parameters: WIDTH (word width), N (channels, 2..16),
//             ARB_MODE (ARB_FIXED = 0, ARB_RR = 1)
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   bus      slave modport of stream_muxn_if (input streams, output stream)
//   pkt_cnt  out  [15:0] completed-packet count, only when the macro
//                 STREAM_MUXN_PKT_CNT_EN is defined
// ---------------------------------------------------------------------------
module stream_muxn
  import stream_muxn_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int N        = 4,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic          clk,
  input  logic          rst,
  stream_muxn_if.slave  bus
`ifdef STREAM_MUXN_PKT_CNT_EN
  ,
  output logic [15:0]   pkt_cnt
`endif
);

  localparam int SEL_W = sel_width(N);

  stream_mux_state_t state;
  logic [SEL_W-1:0]  lock_ch;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  arb_grant;
  logic              arb_any;
  logic [SEL_W-1:0]  sel_ch;
  logic              sel_ok;
  logic              load;
  logic              xfer;
  logic              xfer_last;

  stream_arb_n #(
    .N    (N),
    .MODE (ARB_MODE)
  ) u_arb (
    .req   (bus.in_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .any   (arb_any)
  );

  // Handshake decode. While locked only lock_ch may be ready; in IDLE the
  // arbiter winner is ready, and nobody is when no channel requests.
  always_comb begin
    load   = ~bus.out_valid | bus.out_ready;
    sel_ch = arb_grant;
    sel_ok = arb_any;
    if (state == MUX_LOCKED) begin
      sel_ch = lock_ch;
      sel_ok = 1'b1;
    end
    bus.in_ready = '0;
    if (!rst && load && sel_ok) bus.in_ready[sel_ch] = 1'b1;
    xfer      = |(bus.in_valid & bus.in_ready);
    xfer_last = xfer & bus.in_last[sel_ch];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state         <= MUX_IDLE;
      lock_ch       <= '0;
      rr_ptr        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
    end else begin
      // Output register: holds while stalled, otherwise refills or empties.
      if (load) begin
        bus.out_valid <= xfer;
        if (xfer) begin
          bus.out_data <= bus.in_data[sel_ch];
          bus.out_last <= bus.in_last[sel_ch];
          bus.out_sel  <= sel_ch;
        end
      end

      if (xfer) begin
        case (state)
          MUX_IDLE: begin
            if (!xfer_last) begin
              state   <= MUX_LOCKED;
              lock_ch <= sel_ch;
            end
          end
          MUX_LOCKED: begin
            if (xfer_last) state <= MUX_IDLE;
          end
          default: state <= MUX_IDLE;
        endcase
      end

      // Pointer moves past the channel that just finished a packet, so the
      // next arbitration (one cycle later) starts at the following channel.
      if (xfer_last) begin
        rr_ptr <= (int'(sel_ch) == N - 1) ? '0 : sel_ch + 1'b1;
      end
    end
  end

`ifdef STREAM_MUXN_PKT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)            pkt_cnt <= '0;
    else if (xfer_last) pkt_cnt <= pkt_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_stream_muxn.sv
// ---------------------------------------------------------------------------
// tb_stream_muxn
// Directed bench for stream_muxn (WIDTH=8, N=4) with one fixed-priority and
// one round-robin instance sharing clk/rst. Inputs change 1 time unit after
// the rising edge; outputs are examined before the next rising edge.
// Define STREAM_MUXN_PKT_CNT_EN to also exercise the packet counter.
// ---------------------------------------------------------------------------
module tb_stream_muxn;
  import stream_muxn_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  stream_muxn_if #(.WIDTH(W), .N(N)) if_fix ();
  stream_muxn_if #(.WIDTH(W), .N(N)) if_rr ();

`ifdef STREAM_MUXN_PKT_CNT_EN
  logic [15:0] cnt_fix;
  logic [15:0] cnt_rr;
`endif

  stream_muxn #(.WIDTH(W), .N(N), .ARB_MODE(ARB_FIXED)) u_fix (
    .clk (clk),
    .rst (rst),
    .bus (if_fix)
`ifdef STREAM_MUXN_PKT_CNT_EN
    ,
    .pkt_cnt (cnt_fix)
`endif
  );

  stream_muxn #(.WIDTH(W), .N(N), .ARB_MODE(ARB_RR)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (if_rr)
`ifdef STREAM_MUXN_PKT_CNT_EN
    ,
    .pkt_cnt (cnt_rr)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_fix.in_valid = '0; if_fix.in_last = '0; if_fix.in_data = '0; if_fix.out_ready = 1'b1;
    if_rr.in_valid  = '0; if_rr.in_last  = '0; if_rr.in_data  = '0; if_rr.out_ready  = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    if_fix.in_valid = 4'b1111; if_fix.in_last = 4'b1111;
    if_rr.in_valid  = 4'b1111; if_rr.in_last  = 4'b1111;
    for (int i = 0; i < N; i++) begin
      if_fix.in_data[i] = 8'(8'h10 + i);
      if_rr.in_data[i]  = 8'(8'h10 + i);
    end
    rst = 1'b1;
    cyc();
    cyc();
    checks++; if (if_fix.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", if_fix.out_valid); end
    checks++; if (if_fix.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", if_fix.in_ready); end
    checks++; if (if_fix.out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got=%0d exp=0", if_fix.out_sel); end
    checks++; if (if_fix.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", if_fix.out_data); end
    checks++; if (if_rr.out_valid !== 1'b0 || if_rr.in_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_rr got valid=%b ready=%b exp 0/0000", if_rr.out_valid, if_rr.in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (if_fix.in_ready !== 4'b0001) begin errors++; $display("FAIL first_grant_fix got=%b exp=0001", if_fix.in_ready); end
    checks++; if (if_rr.in_ready !== 4'b0001) begin errors++; $display("FAIL first_grant_rr got=%b exp=0001", if_rr.in_ready); end
    cyc();
    checks++; if (if_fix.out_valid !== 1'b1 || if_fix.out_sel !== 2'd0 || if_fix.out_data !== 8'h10) begin
      errors++; $display("FAIL first_word got v=%b sel=%0d d=%h exp v=1 sel=0 d=10", if_fix.out_valid, if_fix.out_sel, if_fix.out_data); end
    idle_inputs();
    cyc();
    checks++; if (if_fix.out_valid !== 1'b0) begin errors++; $display("FAIL drain_after_reset got=%b exp=0", if_fix.out_valid); end
  endtask

  task automatic test_fixed_priority();
    idle_inputs();
    if_fix.in_valid = 4'b1010; if_fix.in_last = 4'b1111;
    if_fix.in_data[1] = 8'hA1; if_fix.in_data[3] = 8'hA3;
    #1;
    checks++; if (if_fix.in_ready !== 4'b0010) begin errors++; $display("FAIL fixed_ready1 got=%b exp=0010", if_fix.in_ready); end
    cyc();
    checks++; if (if_fix.out_valid !== 1'b1 || if_fix.out_sel !== 2'd1 || if_fix.out_data !== 8'hA1) begin
      errors++; $display("FAIL fixed_word1 got v=%b sel=%0d d=%h exp v=1 sel=1 d=a1", if_fix.out_valid, if_fix.out_sel, if_fix.out_data); end
    if_fix.in_valid = 4'b1000;
    #1;
    checks++; if (if_fix.in_ready !== 4'b1000) begin errors++; $display("FAIL fixed_ready2 got=%b exp=1000", if_fix.in_ready); end
    cyc();
    checks++; if (if_fix.out_valid !== 1'b1 || if_fix.out_sel !== 2'd3 || if_fix.out_data !== 8'hA3) begin
      errors++; $display("FAIL fixed_word2 got v=%b sel=%0d d=%h exp v=1 sel=3 d=a3", if_fix.out_valid, if_fix.out_sel, if_fix.out_data); end
    if_fix.in_valid = 4'b0000;
    cyc();
    checks++; if (if_fix.out_valid !== 1'b0) begin errors++; $display("FAIL fixed_empty got=%b exp=0", if_fix.out_valid); end
  endtask

  task automatic test_packet_lock();
    idle_inputs();
    if_fix.in_valid = 4'b0100; if_fix.in_last = 4'b0000; if_fix.in_data[2] = 8'hC1;
    #1;
    checks++; if (if_fix.in_ready !== 4'b0100) begin errors++; $display("FAIL lock_ready1 got=%b exp=0100", if_fix.in_ready); end
    cyc();
    checks++; if (if_fix.out_sel !== 2'd2 || if_fix.out_data !== 8'hC1 || if_fix.out_last !== 1'b0) begin
      errors++; $display("FAIL lock_w1 got sel=%0d d=%h l=%b exp sel=2 d=c1 l=0", if_fix.out_sel, if_fix.out_data, if_fix.out_last); end
    if_fix.in_valid = 4'b0101; if_fix.in_last = 4'b0001;
    if_fix.in_data[2] = 8'hC2; if_fix.in_data[0] = 8'hB0;
    #1;
    checks++; if (if_fix.in_ready !== 4'b0100) begin errors++; $display("FAIL lock_hold_ready got=%b exp=0100", if_fix.in_ready); end
    cyc();
    checks++; if (if_fix.out_sel !== 2'd2 || if_fix.out_data !== 8'hC2) begin
      errors++; $display("FAIL lock_w2 got sel=%0d d=%h exp sel=2 d=c2", if_fix.out_sel, if_fix.out_data); end
    if_fix.in_data[2] = 8'hC3; if_fix.in_last = 4'b0101;
    cyc();
    checks++; if (if_fix.out_sel !== 2'd2 || if_fix.out_data !== 8'hC3 || if_fix.out_last !== 1'b1) begin
      errors++; $display("FAIL lock_w3 got sel=%0d d=%h l=%b exp sel=2 d=c3 l=1", if_fix.out_sel, if_fix.out_data, if_fix.out_last); end
    if_fix.in_valid = 4'b0001;
    #1;
    checks++; if (if_fix.in_ready !== 4'b0001) begin errors++; $display("FAIL unlock_ready got=%b exp=0001", if_fix.in_ready); end
    cyc();
    checks++; if (if_fix.out_sel !== 2'd0 || if_fix.out_data !== 8'hB0 || if_fix.out_valid !== 1'b1) begin
      errors++; $display("FAIL after_lock got sel=%0d d=%h v=%b exp sel=0 d=b0 v=1", if_fix.out_sel, if_fix.out_data, if_fix.out_valid); end
    idle_inputs();
    cyc();
  endtask

  task automatic test_reset_abort();
    idle_inputs();
    if_fix.in_valid = 4'b0100; if_fix.in_last = 4'b0000; if_fix.in_data[2] = 8'hD1;
    cyc();
    rst = 1'b1;
    if_fix.in_valid = 4'b0000;
    cyc();
    checks++; if (if_fix.out_valid !== 1'b0) begin errors++; $display("FAIL abort_drop got=%b exp=0", if_fix.out_valid); end
    rst = 1'b0;
    if_fix.in_valid = 4'b0001; if_fix.in_last = 4'b0001; if_fix.in_data[0] = 8'hE0;
    #1;
    checks++; if (if_fix.in_ready !== 4'b0001) begin errors++; $display("FAIL abort_unlock got=%b exp=0001", if_fix.in_ready); end
    cyc();
    checks++; if (if_fix.out_sel !== 2'd0 || if_fix.out_data !== 8'hE0) begin
      errors++; $display("FAIL abort_next got sel=%0d d=%h exp sel=0 d=e0", if_fix.out_sel, if_fix.out_data); end
    idle_inputs();
    cyc();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    if_fix.in_valid = 4'b0100; if_fix.in_last = 4'b0000; if_fix.in_data[2] = 8'hF1;
    cyc();
    if_fix.out_ready = 1'b0; if_fix.in_data[2] = 8'hF2;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (if_fix.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, if_fix.in_ready); end
      cyc();
      checks++; if (if_fix.out_valid !== 1'b1 || if_fix.out_data !== 8'hF1) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h exp v=1 d=f1", k, if_fix.out_valid, if_fix.out_data); end
    end
    if_fix.out_ready = 1'b1;
    #1;
    checks++; if (if_fix.in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release got=%b exp=0100", if_fix.in_ready); end
    cyc();
    checks++; if (if_fix.out_data !== 8'hF2 || if_fix.out_sel !== 2'd2) begin
      errors++; $display("FAIL bp_next got d=%h sel=%0d exp d=f2 sel=2", if_fix.out_data, if_fix.out_sel); end
    if_fix.in_data[2] = 8'hF3; if_fix.in_last = 4'b0100;
    cyc();
    checks++; if (if_fix.out_data !== 8'hF3 || if_fix.out_last !== 1'b1) begin
      errors++; $display("FAIL bp_last got d=%h l=%b exp d=f3 l=1", if_fix.out_data, if_fix.out_last); end
    idle_inputs();
    cyc();
  endtask

  task automatic test_round_robin();
    int exp_ch;
    idle_inputs();
    do_reset();
    if_rr.in_valid = 4'b1111; if_rr.in_last = 4'b1111;
    for (int i = 0; i < N; i++) if_rr.in_data[i] = 8'(8'h40 + i);
    for (int k = 0; k < 5; k++) begin
      exp_ch = k % N;
      cyc();
      checks++; if (if_rr.out_sel !== 2'(exp_ch) || if_rr.out_data !== 8'(8'h40 + exp_ch) || if_rr.out_valid !== 1'b1) begin
        errors++; $display("FAIL rr_seq[%0d] got sel=%0d d=%h exp sel=%0d d=%h", k, if_rr.out_sel, if_rr.out_data, exp_ch, 8'(8'h40 + exp_ch)); end
    end
    idle_inputs();
    cyc();
  endtask

`ifdef STREAM_MUXN_PKT_CNT_EN
  task automatic test_pkt_cnt();
    idle_inputs();
    do_reset();
    checks++; if (cnt_fix !== 16'd0) begin errors++; $display("FAIL pkt_cnt_reset got=%0d exp=0", cnt_fix); end
    if_fix.in_valid = 4'b0010; if_fix.in_last = 4'b0010; if_fix.in_data[1] = 8'h77;
    cyc(); cyc(); cyc();
    idle_inputs();
    cyc();
    checks++; if (cnt_fix !== 16'd3) begin errors++; $display("FAIL pkt_cnt_three got=%0d exp=3", cnt_fix); end
    checks++; if (cnt_rr !== 16'd0) begin errors++; $display("FAIL pkt_cnt_idle_rr got=%0d exp=0", cnt_rr); end
  endtask
`endif

  // Random sources on the fixed-priority instance: each channel emits words
  // tagged {channel, sequence}; valid is held until accepted. The sink
  // checks per-channel order, last flags and that packets never interleave.
  task automatic test_random_scoreboard();
    logic [N-1:0] v, lst, hs;
    logic [5:0]   src_seq [N];
    logic [5:0]   exp_seq [N];
    logic         src_open [N];
    logic         last_hist [N][64];
    int           sent, recv, prev_ch, ch, cycles;
    logic         prev_open, take;
    idle_inputs();
    do_reset();
    v = '0; lst = '0; sent = 0; recv = 0; prev_ch = 0; prev_open = 1'b0; cycles = 0;
    for (int c = 0; c < N; c++) begin
      src_seq[c] = '0; exp_seq[c] = '0; src_open[c] = 1'b0;
      for (int s = 0; s < 64; s++) last_hist[c][s] = 1'b0;
    end
    while (!(sent >= 100 && v == '0 && recv == sent) && cycles < 4000) begin
      for (int c = 0; c < N; c++) begin
        if (!v[c] && (src_open[c] || sent < 100) && ($urandom_range(0, 1) == 1)) begin
          v[c]   = 1'b1;
          lst[c] = (sent >= 100) || ($urandom_range(0, 2) == 0);
          if_fix.in_data[c] = {2'(c), src_seq[c]};
        end
      end
      if_fix.in_valid  = v;
      if_fix.in_last   = lst;
      if_fix.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      hs   = if_fix.in_valid & if_fix.in_ready;
      take = if_fix.out_valid & if_fix.out_ready;
      if (take) begin
        ch = int'(if_fix.out_data[7:6]);
        checks++; if (if_fix.out_sel !== 2'(ch)) begin
          errors++; $display("FAIL sb_sel got=%0d exp=%0d", if_fix.out_sel, ch); end
        checks++; if (if_fix.out_data[5:0] !== exp_seq[ch] || (prev_open && ch != prev_ch)) begin
          errors++; $display("FAIL sb_order ch=%0d got seq=%0d exp seq=%0d open=%b prev_ch=%0d", ch, if_fix.out_data[5:0], exp_seq[ch], prev_open, prev_ch); end
        checks++; if (if_fix.out_last !== last_hist[ch][exp_seq[ch]]) begin
          errors++; $display("FAIL sb_last ch=%0d got=%b exp=%b", ch, if_fix.out_last, last_hist[ch][exp_seq[ch]]); end
        exp_seq[ch] = exp_seq[ch] + 6'd1;
        prev_open   = !if_fix.out_last;
        prev_ch     = ch;
        recv++;
      end
      for (int c = 0; c < N; c++) begin
        if (hs[c]) begin
          last_hist[c][src_seq[c]] = lst[c];
          src_seq[c]  = src_seq[c] + 6'd1;
          src_open[c] = !lst[c];
          v[c]        = 1'b0;
          sent++;
        end
      end
      cyc();
      cycles++;
    end
    checks++; if (cycles >= 4000 || recv != sent || sent < 100) begin
      errors++; $display("FAIL sb_complete got recv=%0d sent=%0d cycles=%0d exp recv=sent>=100", recv, sent, cycles); end
    idle_inputs();
    cyc();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fixed_priority();
    test_packet_lock();
    test_reset_abort();
    test_backpressure();
    test_round_robin();
`ifdef STREAM_MUXN_PKT_CNT_EN
    test_pkt_cnt();
`endif
    test_random_scoreboard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
